// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared types and helpers for the TDC merge/FIFO stage
// Contents: FSM state enum, clog2, default result width, coarse majority vote.
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_VOTE,
        ST_CALC
    } state_t;

    // Upper bounds for the majority-vote helper; callers zero-extend into these.
    localparam int MAX_N  = 15;
    localparam int MAX_CW = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int out_width(input int coarse_w, input int fine_w);
        return coarse_w + fine_w + 2;
    endfunction

    // Returns the value held by more than n/2 of the first n phases, or phase 0
    // when no value reaches a strict majority.
    function automatic logic [MAX_CW-1:0] majority_vote(
        input logic [MAX_N*MAX_CW-1:0] stamps,
        input int                      n
    );
        logic [MAX_CW-1:0] winner;
        int                votes;
        winner = stamps[MAX_CW-1:0];
        for (int i = 0; i < MAX_N; i++) begin
            votes = 0;
            for (int j = 0; j < MAX_N; j++) begin
                if (i < n && j < n &&
                    stamps[j*MAX_CW +: MAX_CW] == stamps[i*MAX_CW +: MAX_CW])
                    votes++;
            end
            if (i < n && votes > n / 2) winner = stamps[i*MAX_CW +: MAX_CW];
        end
        return winner;
    endfunction

endpackage

// File: rtl/tdc_merge_fifo_if.sv
// rtl/tdc_merge_fifo_if.sv - measurement input and result readout bundle
// master: start/stop decoders, coarse counters and readout consumer.
// slave : tdc_merge_fifo.
interface tdc_merge_fifo_if #(
    parameter int N        = 3,
    parameter int COARSE_W = 8,
    parameter int FINE_W   = 9,
    parameter int OUT_W    = 19,
    parameter int CNT_W    = 3
);
    logic                  iStartValid;
    logic [FINE_W-1:0]     iStartFine;
    logic                  iStopValid;
    logic [FINE_W-1:0]     iStopFine;
    logic [N*COARSE_W-1:0] iCoarse;
    logic                  iReady;
    logic [OUT_W-1:0]      oData;
    logic                  oValid;
    logic                  oDone;
    logic                  oBusy;
    logic [CNT_W-1:0]      oCount;
    logic                  oOverflow;
    logic [7:0]            oDrops;

    modport master (
        output iStartValid, iStartFine, iStopValid, iStopFine, iCoarse, iReady,
        input  oData, oValid, oDone, oBusy, oCount, oOverflow, oDrops
    );

    modport slave (
        input  iStartValid, iStartFine, iStopValid, iStopFine, iCoarse, iReady,
        output oData, oValid, oDone, oBusy, oCount, oOverflow, oDrops
    );
endinterface

// File: rtl/tdc_result_fifo.sv
// rtl/tdc_result_fifo.sv - synchronous result FIFO with occupancy
// Ports: clk, rst (sync active-high), push/push_data, pop, data (head, 0 when
// empty), count, full, empty. Push while full is legal only together with pop.
module tdc_result_fifo
    import tdc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OUT_W = 19,
    localparam int AW    = clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [OUT_W-1:0] push_data,
    input  logic             pop,
    output logic [OUT_W-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    // Masking keeps the head at zero out of reset, before any entry is written.
    assign data  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/tdc_merge_fifo.sv
// rtl/tdc_merge_fifo.sv - TDC coarse vote, interval calculation and result FIFO
// Ports: clk, iRst (sync active-high), bus (slave): start/stop fine codes and
// valids, packed coarse stamps, iReady; oData/oValid FIFO head, oDone push
// pulse, oBusy, oCount, sticky oOverflow, saturating oDrops.
module tdc_merge_fifo
    import tdc_pkg::*;
#(
    parameter int N            = 3,
    parameter int COARSE_W     = 8,
    parameter int FINE_W       = 9,
    parameter int TAPS_PER_CLK = 320,
    parameter int THRESH       = 200,
    parameter int TIMEOUT      = 16,
    parameter int DEPTH        = 4,
    parameter int OUT_W        = out_width(COARSE_W, FINE_W)
) (
    input  logic            clk,
    input  logic            iRst,
    tdc_merge_fifo_if.slave bus
);
    localparam int CNT_W = clog2(DEPTH) + 1;
    localparam int TMR_W = clog2(TIMEOUT + 1);

    state_t                state, state_next;
    logic [FINE_W-1:0]     start_q, stop_q;
    logic [N*COARSE_W-1:0] coarse_q;
    logic [COARSE_W-1:0]   cf_q, cf_next, c0, maj;
    logic [TMR_W-1:0]      timer;
    logic [7:0]            drops_q;
    logic [8:0]            drops_sum;
    logic [1:0]            drop_inc;
    logic                  overflow_q;
    logic                  push, pop, full, empty, busy, done, lost;
    logic                  timeout;
    logic [OUT_W-1:0]      result, fifo_data;
    logic [CNT_W-1:0]      fifo_count;
    logic [MAX_N*MAX_CW-1:0] stamps_ext;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (iRst) state <= ST_IDLE;
        else      state <= state_next;
    end

    assign timeout = (timer == TMR_W'(TIMEOUT - 1));

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.iStartValid) state_next = bus.iStopValid ? ST_VOTE : ST_ARMED;
            end
            ST_ARMED: begin
                if (bus.iStopValid)       state_next = ST_VOTE;
                else if (bus.iStartValid) state_next = ST_ARMED;
                else if (timeout)         state_next = ST_IDLE;
            end
            ST_VOTE: state_next = ST_CALC;
            ST_CALC: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (state != ST_IDLE);
        push     = 1'b0;
        lost     = 1'b0;
        drop_inc = 2'd0;
        case (state)
            ST_IDLE:  drop_inc = 2'(bus.iStopValid && !bus.iStartValid);
            ST_ARMED: drop_inc = 2'(!bus.iStopValid && (bus.iStartValid || timeout));
            ST_VOTE:  drop_inc = 2'(bus.iStartValid) + 2'(bus.iStopValid);
            ST_CALC: begin
                // A full FIFO still accepts the result if the head leaves this cycle.
                push     = !full || pop;
                lost     = full && !pop;
                drop_inc = 2'(bus.iStartValid) + 2'(bus.iStopValid) + 2'(lost);
            end
            default: ;
        endcase
        done = push;
    end

    // ---------------- coarse vote with fine-code boundary correction ----------------
    always_comb begin
        stamps_ext = '0;
        for (int k = 0; k < N; k++)
            stamps_ext[k*MAX_CW +: MAX_CW] = MAX_CW'(coarse_q[k*COARSE_W +: COARSE_W]);
    end

    assign maj = COARSE_W'(majority_vote(stamps_ext, N));
    assign c0  = coarse_q[COARSE_W-1:0];

    // Phase 0 lagging with a late start tap means it missed a tick that the
    // majority already counted (and symmetrically for a leading phase 0).
    always_comb begin
        cf_next = c0;
        if (c0 < maj && start_q > FINE_W'(THRESH))     cf_next = maj - 1'b1;
        else if (c0 > maj && stop_q > FINE_W'(THRESH)) cf_next = maj + 1'b1;
    end

    assign result = OUT_W'(cf_q) * OUT_W'(TAPS_PER_CLK) + OUT_W'(start_q) - OUT_W'(stop_q);

    // ---------------- datapath registers ----------------
    assign drops_sum = {1'b0, drops_q} + 9'(drop_inc);

    always_ff @(posedge clk) begin
        if (iRst) begin
            start_q    <= '0;
            stop_q     <= '0;
            coarse_q   <= '0;
            cf_q       <= '0;
            timer      <= '0;
            drops_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.iStartValid) begin
                        start_q <= bus.iStartFine;
                        timer   <= '0;
                        if (bus.iStopValid) begin
                            stop_q   <= bus.iStopFine;
                            coarse_q <= bus.iCoarse;
                        end
                    end
                end
                ST_ARMED: begin
                    if (bus.iStopValid) begin
                        stop_q   <= bus.iStopFine;
                        coarse_q <= bus.iCoarse;
                    end else if (bus.iStartValid) begin
                        start_q <= bus.iStartFine;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_VOTE: cf_q <= cf_next;
                default: ;
            endcase
            if (lost) overflow_q <= 1'b1;
            drops_q <= drops_sum[8] ? 8'hFF : drops_sum[7:0];
        end
    end

    // ---------------- result FIFO ----------------
    assign pop = !empty && bus.iReady;

    tdc_result_fifo #(
        .DEPTH (DEPTH),
        .OUT_W (OUT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (iRst),
        .push      (push),
        .push_data (result),
        .pop       (pop),
        .data      (fifo_data),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    assign bus.oData     = fifo_data;
    assign bus.oValid    = !empty;
    assign bus.oDone     = done;
    assign bus.oBusy     = busy;
    assign bus.oCount    = fifo_count;
    assign bus.oOverflow = overflow_q;
    assign bus.oDrops    = drops_q;
endmodule

// File: tb/tb_tdc_merge_fifo.sv
// tb/tb_tdc_merge_fifo.sv - scoreboard bench for tdc_merge_fifo
module tb_tdc_merge_fifo;
    logic clk;
    logic iRst;
    int   n_cmp;
    int   n_err;
    logic [18:0] exp_q[$];

    tdc_merge_fifo_if #(.N(3), .COARSE_W(8), .FINE_W(9), .OUT_W(19), .CNT_W(3)) bus ();

    tdc_merge_fifo dut (
        .clk  (clk),
        .iRst (iRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Independent reference for N=3, THRESH=200, TAPS_PER_CLK=320.
    function automatic logic [18:0] model(input int c0, input int c1, input int c2,
                                          input int s, input int p);
        int m, cf;
        if (c0 == c1 || c0 == c2) m = c0;
        else if (c1 == c2)        m = c1;
        else                      m = c0;
        if (c0 < m && s > 200)      cf = (m + 255) % 256;
        else if (c0 > m && p > 200) cf = (m + 1) % 256;
        else                        cf = c0;
        return 19'(cf * 320 + s - p);
    endfunction

    // Scoreboard: every accepted head word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!iRst && bus.oValid && bus.iReady) begin
            if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
            else                   check("sb_data", bus.oData, exp_q.pop_front());
        end
    end

    task automatic pulse_start(input int s);
        @(posedge clk); #1;
        bus.iStartValid = 1'b1; bus.iStartFine = 9'(s);
        @(posedge clk); #1;
        bus.iStartValid = 1'b0;
    endtask

    task automatic pulse_stop(input int c0, input int c1, input int c2, input int p);
        @(posedge clk); #1;
        bus.iStopValid = 1'b1; bus.iStopFine = 9'(p);
        bus.iCoarse = {8'(c2), 8'(c1), 8'(c0)};
        @(posedge clk); #1;
        bus.iStopValid = 1'b0;
    endtask

    task automatic pulse_both(input int c0, input int c1, input int c2,
                              input int s, input int p, input bit expect_push);
        @(posedge clk); #1;
        bus.iStartValid = 1'b1; bus.iStartFine = 9'(s);
        bus.iStopValid  = 1'b1; bus.iStopFine  = 9'(p);
        bus.iCoarse = {8'(c2), 8'(c1), 8'(c0)};
        if (expect_push) exp_q.push_back(model(c0, c1, c2, s, p));
        @(posedge clk); #1;
        bus.iStartValid = 1'b0; bus.iStopValid = 1'b0;
    endtask

    task automatic meas(input int c0, input int c1, input int c2,
                        input int s, input int p, input bit expect_push);
        pulse_both(c0, c1, c2, s, p, expect_push);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    int exp_drops;
    int done_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; exp_drops = 0;
        iRst = 1'b1;
        bus.iStartValid = 1'b0; bus.iStartFine = '0;
        bus.iStopValid  = 1'b0; bus.iStopFine  = '0;
        bus.iCoarse = '0; bus.iReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 iRst = 1'b0;
        @(negedge clk);
        check("rst_data", bus.oData, 0);
        check("rst_valid", bus.oValid, 0);
        check("rst_done", bus.oDone, 0);
        check("rst_busy", bus.oBusy, 0);
        check("rst_count", bus.oCount, 0);
        check("rst_ovf", bus.oOverflow, 0);
        check("rst_drops", bus.oDrops, 0);

        // Aligned phases with latency checks; stop accepted in cycle t.
        pulse_start(50);
        exp_q.push_back(model(10, 10, 10, 50, 30));
        check("t1_model", model(10, 10, 10, 50, 30), 3220);
        pulse_stop(10, 10, 10, 30);
        @(negedge clk);                       // t+1, VOTE
        check("t1_busy_vote", bus.oBusy, 1);
        check("t1_done_t1", bus.oDone, 0);
        @(negedge clk);                       // t+2, CALC
        check("t1_done_t2", bus.oDone, 1);
        check("t1_valid_t2", bus.oValid, 0);
        @(negedge clk);                       // t+3
        check("t1_valid_t3", bus.oValid, 1);
        check("t1_busy_t3", bus.oBusy, 0);
        check("t1_drops", bus.oDrops, 0);

        // Phase-0 lagging with and without correction, plus wrap/no-majority cases.
        meas(7, 10, 10, 250, 0, 1);
        meas(7, 10, 10, 100, 0, 1);
        meas(0, 255, 255, 250, 0, 1);
        meas(255, 0, 0, 0, 210, 1);
        meas(1, 2, 3, 300, 10, 1);
        drain();
        check("mix_drops", bus.oDrops, 0);

        // Stray stop in IDLE.
        pulse_stop(1, 1, 1, 5);
        exp_drops++;
        @(negedge clk);
        check("stray_busy", bus.oBusy, 0);
        check("stray_drops", bus.oDrops, exp_drops);

        // Timeout: start with no stop.
        pulse_start(40);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.oDone) done_seen++;
        end
        exp_drops++;
        check("to_done", done_seen, 0);
        check("to_busy", bus.oBusy, 0);
        check("to_drops", bus.oDrops, exp_drops);

        // Start arriving during VOTE is dropped; the measurement still completes.
        pulse_both(5, 5, 5, 20, 10, 1);
        bus.iStartValid = 1'b1; bus.iStartFine = 9'd77;
        @(posedge clk); #1;
        bus.iStartValid = 1'b0;
        exp_drops++;
        drain();
        check("vote_drops", bus.oDrops, exp_drops);
        check("vote_busy", bus.oBusy, 0);

        // Overflow: five results with no consumer.
        bus.iReady = 1'b0;
        meas(20, 20, 20, 1, 2, 1);
        meas(21, 21, 22, 3, 4, 1);
        meas(0, 0, 0, 5, 300, 1);
        meas(30, 31, 31, 210, 9, 1);
        meas(40, 40, 40, 6, 7, 0);
        exp_drops++;
        @(negedge clk);
        check("ovf_count", bus.oCount, 4);
        check("ovf_flag", bus.oOverflow, 1);
        check("ovf_drops", bus.oDrops, exp_drops);
        @(posedge clk); #1 bus.iReady = 1'b1;
        drain();
        check("ovf_count_empty", bus.oCount, 0);

        // Reset during VOTE with a non-empty FIFO.
        bus.iReady = 1'b0;
        meas(9, 9, 9, 11, 12, 0);
        pulse_both(9, 9, 9, 13, 14, 0);
        iRst = 1'b1;
        @(posedge clk); #1 iRst = 1'b0;
        @(negedge clk);
        check("mrst_data", bus.oData, 0);
        check("mrst_valid", bus.oValid, 0);
        check("mrst_done", bus.oDone, 0);
        check("mrst_busy", bus.oBusy, 0);
        check("mrst_count", bus.oCount, 0);
        check("mrst_ovf", bus.oOverflow, 0);
        check("mrst_drops", bus.oDrops, 0);
        @(negedge clk);
        check("mrst_nopush", bus.oValid, 0);

        // Simultaneous start/stop in IDLE.
        bus.iReady = 1'b1;
        pulse_both(12, 12, 11, 60, 70, 1);
        @(negedge clk);
        check("sim_valid_t1", bus.oValid, 0);
        @(negedge clk);
        check("sim_done_t2", bus.oDone, 1);
        @(negedge clk);
        check("sim_valid_t3", bus.oValid, 1);
        drain();
        check("sim_drops", bus.oDrops, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tdc_merge_fifo.md
# tdc_merge_fifo

Parametrised successor to the single-measurement TDC merge stage. It takes fine start/stop tap codes and N phase-shifted coarse stamps already in the clk domain, and majority-votes the coarse value with fine-code boundary correction. It then computes the interval and buffers the results in a FIFO with a valid/ready output, so consecutive hits are measured without the host reading between them. It sits between the start/stop decoders plus coarse counters and the readout logic, and replaces the single-shot merging stage.

## Interface
- N, 3: number of coarse counter phases; odd, ≥3; phase 0 is the reference phase.
- COARSE_W, 8: coarse stamp width.
- FINE_W, 9: decoded fine code width.
- TAPS_PER_CLK, 320: fine taps per clk period.
- THRESH, 200: fine-code threshold that enables coarse correction.
- TIMEOUT, 16: cycles allowed between start and stop.
- DEPTH, 4: FIFO depth; power of 2.
- OUT_W, COARSE_W+FINE_W+2: result width.

Ports:
- clk  in  1  sole clock.
- iRst  in  1  reset; synchronous, active-high.
- iStartValid  in  1  one-cycle pulse when iStartFine is valid.
- iStartFine  in  FINE_W  decoded start tap code.
- iStopValid  in  1  one-cycle pulse when iStopFine and iCoarse are valid.
- iStopFine  in  FINE_W  decoded stop tap code.
- iCoarse  in  N*COARSE_W  packed stamps; phase k occupies bits [k*COARSE_W +: COARSE_W].
- iReady  in  1  consumer accepts oData.
- oData  out  OUT_W  FIFO head result.
- oValid  out  1  FIFO not empty.
- oDone  out  1  one-cycle pulse when a result is written to the FIFO.
- oBusy  out  1  a measurement is in flight (state ≠ IDLE).
- oCount  out  clog2(DEPTH)+1  FIFO occupancy.
- oOverflow  out  1  sticky; a result was lost because the FIFO was full.
- oDrops  out  8  saturating count of discarded events.

## Operation
- FSM states: IDLE, ARMED, VOTE, CALC.
- IDLE:
  - iStartValid alone: latch start, go to ARMED, clear the timer.
  - Start and stop in the same cycle: latch both plus iCoarse, go to VOTE.
  - iStopValid alone: ignored, oDrops++.
- ARMED:
  - iStopValid: latch stop and iCoarse, go to VOTE.
  - iStartValid with no stop: overwrite start, restart the timer, oDrops++.
  - Start and stop together: the stop wins and the start is ignored.
  - Timer reaches TIMEOUT-1 with no stop: go to IDLE, oDrops++.
- VOTE: register the corrected coarse value Cf, go to CALC.
  - M = value held by more than N/2 phases. If no majority exists, M = C0.
  - If C0 = M: Cf = C0.
  - If C0 < M and start fine > THRESH: Cf = M−1.
  - If C0 > M and stop fine > THRESH: Cf = M+1.
  - Otherwise Cf = C0.
  - Comparisons are unsigned; ±1 wraps modulo 2^COARSE_W.
- CALC: result = Cf·TAPS_PER_CLK + start − stop.
  - Computed in OUT_W two's complement; no saturation.
  - Write to the FIFO and pulse oDone, then go to IDLE.
  - If the FIFO is full and not popping this cycle: discard the result, set oOverflow, oDrops++, no oDone.
- FIFO behaviour:
  - A pop occurs when oValid and iReady are both high.
  - Push and pop in the same cycle are both performed, including when the FIFO is full; oCount is unchanged.
  - oData is the head entry. It is stable while oValid=1 and iReady=0.
- oDrops saturates at 255.
- iRst mid-operation aborts the measurement with no push, and clears the FIFO and all counters.

## Timing
- Reset values: oData=0, oValid=0, oDone=0, oBusy=0, oCount=0, oOverflow=0, oDrops=0; FSM in IDLE.
- With the stop accepted at cycle t: VOTE at t+1, CALC and push at t+2, oDone high in t+2, oValid=1 and oData valid at t+3 when the FIFO was empty.
- oBusy is high from the cycle after the start/stop is accepted through the CALC cycle.
- A new start is accepted in the cycle after CALC. Input events during VOTE and CALC are ignored and each one does oDrops++.
- Sustained throughput: one result per 3 cycles.

## Structure
- Package tdc_pkg: FSM state enum, clog2 function, OUT_W default expression.
- Sub-module tdc_result_fifo (DEPTH, OUT_W): synchronous FIFO with count, full and empty outputs.
- Majority vote is a combinational function in the package.

## Test plan
Parameters at defaults unless stated.
- Aligned phases: coarse {10,10,10}, start 50, stop 30 → oData=3220; oDone at t+2; oValid at t+3; oDrops=0.
- Phase-0 lagging, correction applied: coarse {7,10,10}, start 250, stop 0 → oData=3130 (Cf=9).
- Phase-0 lagging, no correction: coarse {7,10,10}, start 100, stop 0 → oData=2340 (Cf=7).
- Timeout: start with no stop for 16 cycles → back to IDLE, oDrops=1, no oDone.
- FIFO overflow: iReady=0, 5 measurements → oCount=4, oOverflow=1, oDrops=1. Then iReady=1 → the 4 results drain in order.
- Reset and stray stop:
  - iRst asserted during VOTE → no push; all outputs at reset values the next cycle.
  - Simultaneous start/stop in IDLE → one result at t+3.
